// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector with a registered match pulse and an optional saturating match counter.
// The match counter is built only when the macro SEQDET_COUNT_EN is defined; otherwise count reads zero.
module seq_detect_prog #(
  parameter int              N       = 4,
  parameter int              OVERLAP = 1,
  parameter int              CW      = 8,
  parameter logic [N-1:0]    PAT_RST = 4'b1010
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          x,
  input  logic          en,
  input  logic          load,
  input  logic [N-1:0]  pat_in,
  output logic          y,
  output logic [CW-1:0] count,
  output logic          armed
);

  localparam int             FW   = $clog2(N + 1);
  localparam logic [FW-1:0]  FULL = FW'(N);

  logic [N-1:0]  pat;
  logic [N-1:0]  hist;
  logic [FW-1:0] fill;

  logic [N-1:0]  hist_nxt;
  logic [FW-1:0] fill_inc;
  logic          match;

  // Candidate next state for an enabled sample; match looks at the updated history.
  always_comb begin
    hist_nxt = {hist[N-2:0], x};
    fill_inc = (fill == FULL) ? FULL : fill + 1'b1;
    match    = (fill_inc == FULL) && (hist_nxt == pat);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat  <= PAT_RST;
      hist <= '0;
      fill <= '0;
      y    <= 1'b0;
    end else if (load) begin
      pat  <= pat_in;
      hist <= '0;
      fill <= '0;
      y    <= 1'b0;
    end else if (en) begin
      hist <= hist_nxt;
      // Non-overlapping mode forgets the fill so the next match needs N fresh bits.
      fill <= (match && (OVERLAP == 0)) ? '0 : fill_inc;
      y    <= match;
    end else begin
      y    <= 1'b0;
    end
  end

  assign armed = (fill == FULL);

`ifdef SEQDET_COUNT_EN
  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= '0;
    end else if (en && match && (count_q != {CW{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;
`else
  assign count = '0;
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed bench for seq_detect_prog: three instances (overlapping, non-overlapping, 2-bit counter) share one stimulus stream.
// Expected counts follow SEQDET_COUNT_EN: zero when the counter is not built.
module tb_seq_detect_prog;

`ifdef SEQDET_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       x;
  logic       en;
  logic       load;
  logic [3:0] pat_in;

  logic       y_ov, y_no, y_sat;
  logic       armed_ov, armed_no, armed_sat;
  logic [7:0] count_ov, count_no;
  logic [1:0] count_sat;

  int checks = 0;
  int errors = 0;

  seq_detect_prog #(.N(4), .OVERLAP(1), .CW(8), .PAT_RST(4'b1010)) d_ov (
    .clk(clk), .reset(reset), .x(x), .en(en), .load(load), .pat_in(pat_in),
    .y(y_ov), .count(count_ov), .armed(armed_ov));

  seq_detect_prog #(.N(4), .OVERLAP(0), .CW(8), .PAT_RST(4'b1010)) d_no (
    .clk(clk), .reset(reset), .x(x), .en(en), .load(load), .pat_in(pat_in),
    .y(y_no), .count(count_no), .armed(armed_no));

  seq_detect_prog #(.N(4), .OVERLAP(0), .CW(2), .PAT_RST(4'b1010)) d_sat (
    .clk(clk), .reset(reset), .x(x), .en(en), .load(load), .pat_in(pat_in),
    .y(y_sat), .count(count_sat), .armed(armed_sat));

  // driver: apply one sample, then look 1 ns after the edge
  task automatic cyc(input logic xv, input logic env);
    x  = xv;
    en = env;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] p, input logic env);
    load   = 1'b1;
    pat_in = p;
    x      = 1'b1;
    en     = env;
    @(posedge clk);
    #1;
    load   = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    x = 1'b0; en = 1'b0; load = 1'b0; pat_in = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (y_ov !== 1'b0 || y_no !== 1'b0 || y_sat !== 1'b0) begin
      errors++; $display("FAIL reset_y got %b%b%b exp 000", y_ov, y_no, y_sat);
    end
    checks++; if (armed_ov !== 1'b0 || armed_no !== 1'b0 || armed_sat !== 1'b0) begin
      errors++; $display("FAIL reset_armed got %b%b%b exp 000", armed_ov, armed_no, armed_sat);
    end
    checks++; if (count_ov !== 8'd0 || count_no !== 8'd0 || count_sat !== 2'd0) begin
      errors++; $display("FAIL reset_count got %0d %0d %0d exp 0 0 0", count_ov, count_no, count_sat);
    end
    reset = 1'b1;
  endtask

  task automatic test_overlap;
    logic [5:0] s;
    logic [5:0] e_ov;
    logic [5:0] e_no;
    logic [7:0] c_ov;
    logic [7:0] c_no;
    s = 6'b101010; e_ov = 6'b000101; e_no = 6'b000100;
    c_ov = 8'd0; c_no = 8'd0;
    for (int i = 0; i < 6; i++) begin
      cyc(s[5-i], 1'b1);
      if (CNT_ON && e_ov[5-i]) c_ov++;
      if (CNT_ON && e_no[5-i]) c_no++;
      checks++; if (y_ov !== e_ov[5-i]) begin
        errors++; $display("FAIL overlap_y_ov[%0d] got %b exp %b", i, y_ov, e_ov[5-i]);
      end
      checks++; if (y_no !== e_no[5-i]) begin
        errors++; $display("FAIL overlap_y_no[%0d] got %b exp %b", i, y_no, e_no[5-i]);
      end
      checks++; if (count_ov !== c_ov || count_no !== c_no) begin
        errors++; $display("FAIL overlap_count[%0d] got %0d %0d exp %0d %0d", i, count_ov, count_no, c_ov, c_no);
      end
      if (i == 3) begin
        checks++; if (armed_no !== 1'b0 || armed_ov !== 1'b1) begin
          errors++; $display("FAIL overlap_armed got ov=%b no=%b exp ov=1 no=0", armed_ov, armed_no);
        end
      end
    end
    // idle cycle: y drops, everything else holds
    cyc(1'b1, 1'b0);
    checks++; if (y_ov !== 1'b0 || y_no !== 1'b0) begin
      errors++; $display("FAIL idle_y got %b%b exp 00", y_ov, y_no);
    end
    checks++; if (count_ov !== c_ov || count_no !== c_no || armed_ov !== 1'b1) begin
      errors++; $display("FAIL idle_hold got %0d %0d armed=%b exp %0d %0d armed=1", count_ov, count_no, armed_ov, c_ov, c_no);
    end
  endtask

  task automatic test_load_gap;
    logic [6:0] xs;
    logic [6:0] es;
    logic [6:0] ys;
    do_load(4'b0110, 1'b1);
    checks++; if (count_ov !== 8'd0 || armed_ov !== 1'b0 || y_ov !== 1'b0) begin
      errors++; $display("FAIL load_clear got count=%0d armed=%b y=%b exp 0 0 0", count_ov, armed_ov, y_ov);
    end
    xs = 7'b0111110; es = 7'b1100011; ys = 7'b0000001;
    for (int i = 0; i < 7; i++) begin
      cyc(xs[6-i], es[6-i]);
      checks++; if (y_ov !== ys[6-i]) begin
        errors++; $display("FAIL load_gap_y[%0d] got %b exp %b", i, y_ov, ys[6-i]);
      end
    end
    checks++; if (count_ov !== (CNT_ON ? 8'd1 : 8'd0)) begin
      errors++; $display("FAIL load_gap_count got %0d exp %0d", count_ov, CNT_ON ? 1 : 0);
    end
  endtask

  task automatic test_saturation;
    int  m_sat;
    logic e_sat;
    logic e_ov;
    do_load(4'b1010, 1'b0);
    m_sat = 0;
    for (int i = 0; i < 20; i++) begin
      cyc((i % 2 == 0) ? 1'b1 : 1'b0, 1'b1);
      e_sat = (i % 4 == 3);
      e_ov  = (i >= 3) && (i % 2 == 1);
      if (e_sat) m_sat++;
      checks++; if (y_sat !== e_sat) begin
        errors++; $display("FAIL sat_y[%0d] got %b exp %b", i, y_sat, e_sat);
      end
      checks++; if (y_ov !== e_ov) begin
        errors++; $display("FAIL sat_y_ov[%0d] got %b exp %b", i, y_ov, e_ov);
      end
    end
    checks++; if (count_sat !== (CNT_ON ? 2'd3 : 2'd0)) begin
      errors++; $display("FAIL sat_count got %0d exp %0d", count_sat, CNT_ON ? 3 : 0);
    end
    checks++; if (count_no !== (CNT_ON ? 8'd5 : 8'd0) || count_ov !== (CNT_ON ? 8'd9 : 8'd0)) begin
      errors++; $display("FAIL sat_count_wide got %0d %0d exp %0d %0d", count_no, count_ov, CNT_ON ? 5 : 0, CNT_ON ? 9 : 0);
    end
  endtask

  task automatic test_reset_mid;
    logic [4:0] xs;
    logic [4:0] ys;
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    reset = 1'b0;
    #1;
    checks++; if (armed_ov !== 1'b0 || count_ov !== 8'd0 || y_ov !== 1'b0) begin
      errors++; $display("FAIL reset_mid_async got armed=%b count=%0d y=%b exp 0 0 0", armed_ov, count_ov, y_ov);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    xs = 5'b01010; ys = 5'b00001;
    for (int i = 0; i < 5; i++) begin
      cyc(xs[4-i], 1'b1);
      checks++; if (y_ov !== ys[4-i] || y_no !== ys[4-i]) begin
        errors++; $display("FAIL reset_mid_y[%0d] got %b%b exp %b", i, y_ov, y_no, ys[4-i]);
      end
    end
  endtask

  // scenario sequence and final report
  initial begin
    test_reset;
    test_overlap;
    test_load_gap;
    test_saturation;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
